// File: rtl/cr_prefix_pf_rd_pkg.sv
// cr_prefix_pf_rd_pkg
//   Shared types and constants for the prefix FIFO reader/packer.
//   - PF_RD_BYTES   : byte lanes per packed output word (fixed at 8)
//   - pf_rd_state_e : reader FSM states (ACCUM packs bytes, DISCARD drops an overlong tail)
//   - pf_entry_t    : one prefix FIFO entry {last, data[7:0]}
package cr_prefix_pf_rd_pkg;

    localparam int unsigned PF_RD_BYTES = 8;

    typedef enum logic {
        ACCUM   = 1'b0,
        DISCARD = 1'b1
    } pf_rd_state_e;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } pf_entry_t;

endpackage

// File: rtl/cr_prefix_pf_rd_if.sv
// cr_prefix_pf_rd_if
//   Packed-word valid/ready stream from the prefix FIFO reader to the prefix inserter.
//   - pr_valid : word valid (source)
//   - pr_ready : downstream accept (sink)
//   - pr_data  : packed bytes, lane k = bits 8k+7:8k (source)
//   - pr_bcnt  : valid bytes 1..8 in lanes 0..bcnt-1 (source)
//   - pr_last  : word closes a record (source)
//   Modports: master = word source, slave = word sink.
interface cr_prefix_pf_rd_if;
    import cr_prefix_pf_rd_pkg::*;

    logic                       pr_valid;
    logic                       pr_ready;
    logic [8*PF_RD_BYTES-1:0]   pr_data;
    logic [3:0]                 pr_bcnt;
    logic                       pr_last;

    modport master (
        output pr_valid,
        output pr_data,
        output pr_bcnt,
        output pr_last,
        input  pr_ready
    );

    modport slave (
        input  pr_valid,
        input  pr_data,
        input  pr_bcnt,
        input  pr_last,
        output pr_ready
    );

endinterface

// File: rtl/cr_prefix_pf_rd_acc.sv
// cr_prefix_pf_rd_acc
//   Byte-lane accumulator. Bytes are written little-endian at the write index;
//   the accumulator closes when all lanes are full or a last byte is captured.
//   Ports:
//   - clk, rst : clock, synchronous active-high reset
//   - wr_en    : write wr_data into the next lane
//   - wr_data  : byte to write
//   - wr_last  : written byte closes the record
//   - clear    : empty the accumulator (a same-cycle write lands in lane 0)
//   - data     : lane contents, unused lanes read as zero
//   - cnt      : number of bytes held (0..8)
//   - last     : a last byte has been captured
//   - closed   : accumulator full or holding a last byte
module cr_prefix_pf_rd_acc
    import cr_prefix_pf_rd_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [7:0]                wr_data,
    input  logic                      wr_last,
    input  logic                      clear,
    output logic [8*PF_RD_BYTES-1:0]  data,
    output logic [3:0]                cnt,
    output logic                      last,
    output logic                      closed
);

    logic [PF_RD_BYTES-1:0][7:0] lanes;

    always_ff @(posedge clk) begin
        if (rst) begin
            lanes <= '0;
            cnt   <= '0;
            last  <= 1'b0;
        end else if (clear) begin
            // Emptying zeroes all lanes so a short word carries zeros above bcnt.
            lanes <= '0;
            cnt   <= '0;
            last  <= 1'b0;
            if (wr_en) begin
                lanes[0] <= wr_data;
                cnt      <= 4'd1;
                last     <= wr_last;
            end
        end else if (wr_en) begin
            lanes[cnt[2:0]] <= wr_data;
            cnt             <= cnt + 4'd1;
            last            <= wr_last;
        end
    end

    assign data   = lanes;
    assign closed = (cnt == 4'(PF_RD_BYTES)) || last;

endmodule

// File: rtl/cr_prefix_pf_rd.sv
// cr_prefix_pf_rd
//   Prefix FIFO reader and packer. Drains 9-bit show-ahead FIFO entries
//   ({last, byte}), packs bytes little-endian into up-to-8-byte words and
//   presents them on a valid/ready stream. Records longer than MAX_REC_BYTES
//   are cut at the limit (forced last) and the remaining tail is discarded.
//   Ports:
//   - clk, rst   : clock, synchronous active-high reset
//   - pf_empty   : prefix FIFO empty
//   - pf_dout    : FIFO head entry, valid whenever !pf_empty
//   - pf_rd      : pop strobe, at most one entry per cycle
//   - pr         : packed word stream (cr_prefix_pf_rd_if.master)
//   - pr_rec_cnt : records delivered (wraps)
//   - pr_err_len : sticky, a record exceeded MAX_REC_BYTES
//   Build option: CR_PREFIX_PF_RD_STATS_EN builds the record counter and the
//   length-error flag; without it both outputs are tied to zero.
module cr_prefix_pf_rd
    import cr_prefix_pf_rd_pkg::*;
#(
    parameter int unsigned MAX_REC_BYTES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pf_empty,
    input  logic [8:0]            pf_dout,
    output logic                  pf_rd,
    cr_prefix_pf_rd_if.master     pr,
    output logic [15:0]           pr_rec_cnt,
    output logic                  pr_err_len
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_REC_BYTES);

    pf_rd_state_e state, state_nx;
    pf_entry_t    entry;

    logic [7:0]   rec_len, rec_len_nx, len_inc;
    logic         pop, xfer;
    logic         acc_wr, acc_wr_last, acc_closed, acc_last;
    logic [3:0]   acc_cnt;
    logic [8*PF_RD_BYTES-1:0] acc_data;

    logic         out_valid, out_last;
    logic [3:0]   out_bcnt;
    logic [8*PF_RD_BYTES-1:0] out_data;

    assign entry   = pf_entry_t'(pf_dout);
    assign len_inc = rec_len + 8'd1;

    cr_prefix_pf_rd_acc u_acc (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (acc_wr),
        .wr_data (entry.data),
        .wr_last (acc_wr_last),
        .clear   (xfer),
        .data    (acc_data),
        .cnt     (acc_cnt),
        .last    (acc_last),
        .closed  (acc_closed)
    );

    // FSM state and record length register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACCUM;
            rec_len <= '0;
        end else begin
            state   <= state_nx;
            rec_len <= rec_len_nx;
        end
    end

    // The output word drains in either state; DISCARD only changes what a pop does.
    always_comb begin
        state_nx    = state;
        rec_len_nx  = rec_len;
        acc_wr      = 1'b0;
        acc_wr_last = 1'b0;
        xfer        = acc_closed && (!out_valid || pr.pr_ready);
        pop         = !rst && !pf_empty && ((state == DISCARD) || !acc_closed || xfer);

        if (pop) begin
            unique case (state)
                ACCUM: begin
                    acc_wr = 1'b1;
                    if (entry.last) begin
                        acc_wr_last = 1'b1;
                        rec_len_nx  = '0;
                    end else if (len_inc == MAX_LEN) begin
                        // Length limit reached without a last marker: close the
                        // record here and drop the rest of it.
                        acc_wr_last = 1'b1;
                        rec_len_nx  = '0;
                        state_nx    = DISCARD;
                    end else begin
                        rec_len_nx  = len_inc;
                    end
                end
                DISCARD: begin
                    if (entry.last) begin
                        rec_len_nx = '0;
                        state_nx   = ACCUM;
                    end
                end
                default: state_nx = ACCUM;
            endcase
        end
    end

    assign pf_rd = pop;

    // Output register: loads on xfer, holds while stalled, clears on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bcnt  <= '0;
            out_last  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= acc_data;
            out_bcnt  <= acc_cnt;
            out_last  <= acc_last;
        end else if (pr.pr_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign pr.pr_valid = out_valid;
    assign pr.pr_data  = out_data;
    assign pr.pr_bcnt  = out_bcnt;
    assign pr.pr_last  = out_last;

`ifdef CR_PREFIX_PF_RD_STATS_EN
    logic [15:0] rec_cnt;
    logic        err_len;
    logic        len_err;

    // A length cut only counts as an error when the byte at the limit is not a last.
    assign len_err = pop && (state == ACCUM) && !entry.last && (len_inc == MAX_LEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_cnt <= '0;
            err_len <= 1'b0;
        end else begin
            if (out_valid && pr.pr_ready && out_last)
                rec_cnt <= rec_cnt + 16'd1;
            if (len_err)
                err_len <= 1'b1;
        end
    end

    assign pr_rec_cnt = rec_cnt;
    assign pr_err_len = err_len;
`else
    assign pr_rec_cnt = '0;
    assign pr_err_len = 1'b0;
`endif

endmodule
